// File: rtl/mul_pkg.sv
// Shared types and helpers for the multiplier arbiter.
// Provides FSM state enum, default width and round-robin pick.
package mul_pkg;

  localparam int MUL_W  = 8;
  localparam int MAXREQ = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } mularb_state_t;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } rr_pick_t;

  // Scan far-to-near so the entry closest to ptr wins last.
  function automatic rr_pick_t rr_pick(
    input logic [MAXREQ-1:0] valid,
    input int                nreq,
    input int                ptr
  );
    rr_pick_t r;
    int       k;
    r = '0;
    for (int i = MAXREQ - 1; i >= 0; i--) begin
      if (i < nreq) begin
        k = ptr + i;
        if (k >= nreq) k = k - nreq;
        if (valid[k]) begin
          r.found = 1'b1;
          r.idx   = 32'(k);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mult.sv
// Signed combinational multiplier, full-width product.
// Ports: a, b (n-bit signed) -> p (2n-bit signed).
module mult #(
  parameter int n = 8
) (
  input  logic signed [n-1:0]   a,
  input  logic signed [n-1:0]   b,
  output logic signed [2*n-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/mult_arbiter_rr.sv
// Combinational round-robin picker from a valid vector and pointer.
// Ports: req_valid, rr_ptr -> gnt (one-hot), gnt_id, found.
module rr_arbiter
  import mul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            found
);

  rr_pick_t w_pick;

  assign w_pick = rr_pick(MAXREQ'(req_valid), NREQ, int'(rr_ptr));
  assign found  = w_pick.found;
  assign gnt_id = IDW'(w_pick.idx);
  assign gnt    = found ? (NREQ'(1) << gnt_id) : '0;

endmodule

// File: rtl/mult_arbiter.sv
// Time-shares one signed multiplier among NREQ requesters, round-robin.
// Ports: clk, reset, req_valid/ready/a/b in, rsp_valid/ready/data/id, busy.
module mult_arbiter
  import mul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int n    = MUL_W,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*n-1:0] req_a,
  input  logic [NREQ*n-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [n-1:0]    rsp_data,
  output logic [IDW-1:0]  rsp_id,
  output logic            busy
);

  mularb_state_t r_state, w_next;

  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_gnt_id;
  logic [n-1:0]    r_opa;
  logic [n-1:0]    r_opb;
  logic [n-1:0]    r_rsp_data;
  logic [IDW-1:0]  r_rsp_id;

  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gnt_id;
  logic            w_found;
  logic            w_xfer;
  logic [2*n-1:0]  w_prod;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (r_rr_ptr),
    .gnt       (w_gnt),
    .gnt_id    (w_gnt_id),
    .found     (w_found)
  );

  mult #(
    .n (n)
  ) u_mult (
    .a (r_opa),
    .b (r_opb),
    .p (w_prod)
  );

  // Reset gates the grant so req_ready drops the same instant.
  assign w_xfer    = (r_state == IDLE) && w_found && !reset;
  assign req_ready = w_xfer ? w_gnt : '0;
  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_xfer) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_gnt_id   <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
    end else begin
      if (w_xfer) begin
        r_opa    <= req_a[w_gnt_id*n +: n];
        r_opb    <= req_b[w_gnt_id*n +: n];
        r_gnt_id <= w_gnt_id;
        r_rr_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
      end
      if (r_state == EXEC) begin
        r_rsp_data <= w_prod[n-1:0];
        r_rsp_id   <= r_gnt_id;
      end
    end
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Time-shares one signed n-bit `mult` instance between NREQ requesters (ALU, address generator, future MAC users).
- Round-robin arbitration, valid/ready handshake per requester, operands and result registered.
- Single response channel tagged with requester ID and backpressured by rsp_ready.
- Sits between requesting datapath units and the single dedicated hardware multiplier.

Parameters:
- NREQ, 4, number of requesters; must be ≥2.
- n, 8, operand and result width in bits.
- IDW, $clog2(NREQ), width of the requester ID tag.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand-valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high (one-hot or zero).
- req_a  in  NREQ*n  packed operand A, requester i at [i*n +: n], signed.
- req_b  in  NREQ*n  packed operand B, same packing, signed.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  n  signed product, low n bits.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE, rr_ptr=0.
  - opA=opB=0, rsp_valid=0, rsp_data=0, rsp_id=0.
  - req_ready=0, busy=0.
- FSM states:
  - IDLE: wait for a request.
  - EXEC: operands registered, multiply in progress.
  - RESP: result presented.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, …, NREQ-1, 0, …).
  - req_ready[grant] is asserted combinationally in the same cycle, only in IDLE.
  - Transfer occurs when req_valid & req_ready are both high. On transfer:
    - latch opA/opB from the granted slice and record gnt_id;
    - rr_ptr ← (gnt_id+1) mod NREQ;
    - go to EXEC.
  - With no valid request, stay in IDLE and leave rr_ptr unchanged.
- EXEC (exactly 1 cycle):
  - mult sees the opA/opB registers.
  - At the cycle end, rsp_data ← product[n-1:0] and rsp_id ← gnt_id; go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are stable until the handshake.
  - If rsp_ready=1, deassert rsp_valid next cycle and return to IDLE.
  - Otherwise hold RESP indefinitely.
- Latency and throughput:
  - Request accept to rsp_valid = 2 cycles.
  - Minimum issue interval is 3 cycles (accept, EXEC, RESP with rsp_ready high). No overlap.
- Arithmetic:
  - Signed two's-complement; result truncated to the low n bits with no saturation and no overflow flag.
  - If either operand is 0, the result is 0.
- Requesters must hold req_valid, req_a and req_b stable until req_ready. The arbiter does not re-sample after a transfer.
- req_valid changes while not granted have no effect. Deasserting req_valid before grant is legal: the request is simply lost.
- Simultaneous requests: one winner per arbitration; losers keep req_ready=0 and are served in later rounds. No requester starves for more than NREQ-1 grants.
- rr_ptr wrap: NREQ-1 → 0.
- Reset mid-operation (EXEC or RESP) aborts the operation:
  - outputs return to reset values the same instant (asynchronous);
  - the pending result is discarded and never presented.

Decomposition:
- Shared package mul_pkg:
  - enum mularb_state_t {IDLE, EXEC, RESP};
  - localparam default width 8.
  - function rr_pick(valid vector, pointer) returning index plus a found flag.
- One sub-module is natural: rr_arbiter (combinational round-robin pick from req_valid and rr_ptr; outputs a one-hot grant and an encoded gnt_id). It is reusable by future shared-resource blocks.
- The multiplier is an instance of the existing `mult` with parameter n.

Test Plan:
- Single request: after reset, req_valid[2]=1, a=5, b=-3 → req_ready[2] in the same cycle; rsp_valid 2 cycles later with rsp_data=-15 (8'hF1), rsp_id=2; busy high throughout.
- Contention and fairness: all four req_valid held high with a=i+1, b=2 → grant order 0,1,2,3,0; rsp_data 2,4,6,8; rsp_id matches each grant; never more than one req_ready high.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid/rsp_data/rsp_id stable, no req_ready asserted; rsp_ready=1 → IDLE next cycle.
- Truncation and zero: a=100, b=3 → rsp_data=8'h2C (300 mod 256); a=-128, b=-1 → 8'h80; a=0, b=-77 → 0.
- Wrap-around: rr_ptr=3 after granting 2; requests on 0 and 3 → 3 granted first, then 0.
- Async reset: assert reset in RESP with rsp_valid=1 → rsp_valid=0, busy=0, req_ready=0 immediately; after release, no stale response appears and a new request completes normally.
